ped_request_conditioner: RTL

Upstream stage of the pedestrian-crossing traffic light controller. It conditions the raw crosswalk push-button: synchronises it, debounces it, latches one press into a held request, and drives that request to the light controller's pedestrian_request input. The request is held until the controller grants a crossing, shown by its pedestrian_light output fed back here. After each crossing the block enforces a cooldown, drives the "WAIT" lamp and keeps a saturating count of crossings served.

---
 rtl/ped_request_conditioner.sv | 111 +++++++++++
 1 files changed

// File: rtl/ped_request_conditioner.sv
// Crosswalk push-button conditioner: two-flop synchroniser, debounce, press detect,
// and a Moore FSM holding one crossing request, enforcing cooldown and counting crossings.
module ped_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic             ped_light,
    output logic             pedestrian_request,
    output logic             wait_lamp,
    output logic [CNT_W-1:0] serve_count
);

    localparam logic [7:0]       DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]      COOL_LOAD = 16'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_SERVING,
        ST_COOLDOWN
    } state_t;

    logic             r_sync_meta;
    logic             r_btn_sync;
    logic             r_btn_stable;
    logic             r_btn_prev;
    logic [7:0]       r_db_cnt;
    state_t           r_state;
    logic [15:0]      r_cool_cnt;
    logic             r_queued;
    logic [CNT_W-1:0] r_serve_count;
    logic             w_press;

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_meta <= 1'b0;
            r_btn_sync  <= 1'b0;
        end else begin
            r_sync_meta <= btn_raw;
            r_btn_sync  <= r_sync_meta;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_stable <= 1'b0;
            r_btn_prev   <= 1'b0;
            r_db_cnt     <= 8'd0;
        end else begin
            r_btn_prev <= r_btn_stable;
            if (r_btn_sync == r_btn_stable) begin
                r_db_cnt <= 8'd0;
            end else if (r_db_cnt == DB_LAST) begin
                r_btn_stable <= r_btn_sync;
                r_db_cnt     <= 8'd0;
            end else begin
                r_db_cnt <= r_db_cnt + 8'd1;
            end
        end
    end

    assign w_press = r_btn_stable & ~r_btn_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cool_cnt    <= 16'd0;
            r_queued      <= 1'b0;
            r_serve_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_press) r_state <= ST_PENDING;
                end
                ST_PENDING: begin
                    if (ped_light) r_state <= ST_SERVING;
                end
                ST_SERVING: begin
                    if (!ped_light) begin
                        r_state    <= ST_COOLDOWN;
                        r_cool_cnt <= COOL_LOAD;
                        if (r_serve_count != CNT_MAX) r_serve_count <= r_serve_count + CNT_W'(1);
                    end
                end
                ST_COOLDOWN: begin
                    // A press on the final cooldown cycle still counts via w_press.
                    if (r_cool_cnt == 16'd0) begin
                        r_state  <= (r_queued | w_press) ? ST_PENDING : ST_IDLE;
                        r_queued <= 1'b0;
                    end else begin
                        r_cool_cnt <= r_cool_cnt - 16'd1;
                        if (w_press) r_queued <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pedestrian_request = (r_state == ST_PENDING);
    assign wait_lamp          = (r_state == ST_PENDING) | ((r_state == ST_COOLDOWN) & r_queued);
    assign serve_count        = r_serve_count;

endmodule
